seg_scan_ctrl: RTL and testbench

//  Parametrised multi-digit 7-segment scan controller for the common-cathode board displays.

---
 rtl/seg_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit nibble/DP/blank latching with
// frame-aligned (tear-free) display updates, leading-zero suppression and ghost blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 12000,
    parameter int BLANK_CYC      = 120,
    parameter int HEX_EN         = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    tick;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend_lz;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;
    logic                    disp_lz;

    logic [NUM_DIGITS-1:0]   suppress;
    logic                    lead;
    logic [3:0]              cur_nib;
    logic [7:0]              seg_digit;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        if (HEX_EN == 0 && nib > 4'd9) pat = 7'h40;
        return pat;
    endfunction

    assign tick       = (cnt == CNT_LAST);
    assign frame_done = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load landing on the frame boundary bypasses the pending stage entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '1;
            disp_lz    <= 1'b0;
        end else if (load && frame_done) begin
            disp_data  <= digit_data;
            disp_dp    <= dp_in;
            disp_blank <= blank_in;
            disp_lz    <= lz_suppress;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_data  <= digit_data;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pend_lz    <= lz_suppress;
            pend_valid <= 1'b1;
        end else if (frame_done && pend_valid) begin
            disp_data  <= pend_data;
            disp_dp    <= pend_dp;
            disp_blank <= pend_blank;
            disp_lz    <= pend_lz;
            pend_valid <= 1'b0;
        end
    end

    // Suppression runs from the MSD down and stops at the first non-zero or blanked digit.
    always_comb begin
        suppress = '0;
        lead     = disp_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (disp_data[4*i +: 4] == 4'h0) && !disp_blank[i]) begin
                suppress[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib = disp_data[{idx, 2'b00} +: 4];
        if (disp_blank[idx]) begin
            seg_digit = 8'h00;
        end else if (suppress[idx]) begin
            seg_digit = {disp_dp[idx], 7'h00};
        end else begin
            seg_digit = {disp_dp[idx], decode(cur_nib)};
        end
        seg_next = (cnt < CNT_BLANK) ? 8'h00 : seg_digit;
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= 8'h00;
            dig_sel <= SEL_IDLE;
        end else begin
            seg_out <= seg_next;
            dig_sel <= sel_onehot ^ SEL_IDLE;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 4 clk per slot, 1 blank cycle);
// a second instance with HEX_EN=0 checks the dash pattern.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lz_suppress = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  seg_out, seg_out_b;
    logic [3:0]  dig_sel, dig_sel_b;
    logic        frame_done, frame_done_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_q_b[$];
    logic [7:0]  cur, cur_b, exp_seg;
    logic [3:0]  exp_sel;

    seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .HEX_EN(1), .DIG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .digit_data(digit_data), .dp_in(dp_in), .blank_in(blank_in),
        .lz_suppress(lz_suppress), .load(load), .seg_out(seg_out), .dig_sel(dig_sel),
        .frame_done(frame_done));

    seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .HEX_EN(0), .DIG_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .digit_data(digit_data), .dp_in(dp_in), .blank_in(blank_in),
        .lz_suppress(lz_suppress), .load(load), .seg_out(seg_out_b), .dig_sel(dig_sel_b),
        .frame_done(frame_done_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic to_frame_start();
        while (cyc % 16 != 0) tick();
    endtask

    task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                              input logic lz);
        digit_data  = d;
        dp_in       = dp;
        blank_in    = bl;
        lz_suppress = lz;
        load        = 1'b1;
    endtask

    task automatic load_and_skip_frame(input logic [15:0] d, input logic [3:0] dp,
                                       input logic [3:0] bl, input logic lz);
        to_frame_start();
        drive_load(d, dp, bl, lz);
        tick();
        load = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (seg_out !== 8'h00) begin errors++; $display("FAIL rst_seg got %h exp 00", seg_out); end
        checks++;
        if (dig_sel !== 4'hF) begin errors++; $display("FAIL rst_sel got %b exp 1111", dig_sel); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got %b exp 0", frame_done); end
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            exp_sel = 4'hF ^ (4'b0001 << ((k / 4) % 4));
            checks++;
            if (seg_out !== 8'h00) begin errors++; $display("FAIL idle_seg k=%0d got %h exp 00", k, seg_out); end
            checks++;
            if (dig_sel !== exp_sel) begin errors++; $display("FAIL idle_sel k=%0d got %b exp %b", k, dig_sel, exp_sel); end
            checks++;
            if (frame_done !== (cyc % 16 == 15)) begin
                errors++; $display("FAIL idle_fd k=%0d got %b exp %b", k, frame_done, (cyc % 16 == 15));
            end
        end
    endtask

    task automatic test_load_frame();
        to_frame_start();
        drive_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        repeat (4) exp_q.push_back(8'h00);
        exp_q.push_back(8'h66); exp_q.push_back(8'h4F); exp_q.push_back(8'h5B); exp_q.push_back(8'h06);
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k == 0) load = 1'b0;
            if (k % 4 == 0) cur = exp_q.pop_front();
            exp_seg = (k % 4 == 0) ? 8'h00 : cur;
            exp_sel = 4'hF ^ (4'b0001 << ((k / 4) % 4));
            checks++;
            if (seg_out !== exp_seg) begin errors++; $display("FAIL load_seg k=%0d got %h exp %h", k, seg_out, exp_seg); end
            checks++;
            if (dig_sel !== exp_sel) begin errors++; $display("FAIL load_sel k=%0d got %b exp %b", k, dig_sel, exp_sel); end
        end
    endtask

    task automatic test_lz_hex();
        load_and_skip_frame(16'h00A5, 4'b0100, 4'b0000, 1'b1);
        exp_q.push_back(8'h6D); exp_q.push_back(8'h77); exp_q.push_back(8'h80); exp_q.push_back(8'h00);
        exp_q_b.push_back(8'h6D); exp_q_b.push_back(8'h40); exp_q_b.push_back(8'h80); exp_q_b.push_back(8'h00);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k % 4 == 0) begin cur = exp_q.pop_front(); cur_b = exp_q_b.pop_front(); end
            exp_seg = (k % 4 == 0) ? 8'h00 : cur;
            checks++;
            if (seg_out !== exp_seg) begin errors++; $display("FAIL lz_seg k=%0d got %h exp %h", k, seg_out, exp_seg); end
            exp_seg = (k % 4 == 0) ? 8'h00 : cur_b;
            checks++;
            if (seg_out_b !== exp_seg) begin errors++; $display("FAIL nohex_seg k=%0d got %h exp %h", k, seg_out_b, exp_seg); end
        end
    endtask

    task automatic test_zero_blank();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                load_and_skip_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);
                exp_q.push_back(8'h3F); repeat (3) exp_q.push_back(8'h00);
            end else begin
                load_and_skip_frame(16'h0000, 4'b0001, 4'b0001, 1'b1);
                repeat (4) exp_q.push_back(8'h00);
            end
            for (int k = 0; k < 16; k++) begin
                tick();
                if (k % 4 == 0) cur = exp_q.pop_front();
                exp_seg = (k % 4 == 0) ? 8'h00 : cur;
                checks++;
                if (seg_out !== exp_seg) begin
                    errors++; $display("FAIL zero_seg ph=%0d k=%0d got %h exp %h", ph, k, seg_out, exp_seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        to_frame_start();
        repeat (5) tick();
        drive_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        repeat (4) exp_q.push_back(8'h06);
        tick();
        load = 1'b0;
        repeat (2) tick();
        drive_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        exp_q.delete();
        repeat (4) exp_q.push_back(8'h5B);
        tick();
        load = 1'b0;
        to_frame_start();
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k % 4 == 0) cur = exp_q.pop_front();
            exp_seg = (k % 4 == 0) ? 8'h00 : cur;
            checks++;
            if (seg_out !== exp_seg) begin errors++; $display("FAIL b2b_seg k=%0d got %h exp %h", k, seg_out, exp_seg); end
        end
        while (cyc % 16 != 15) tick();
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL coinc_fd got %b exp 1", frame_done); end
        drive_load(16'h9876, 4'b0000, 4'b0000, 1'b0);
        repeat (2) begin
            exp_q.push_back(8'h7D); exp_q.push_back(8'h07); exp_q.push_back(8'h7F); exp_q.push_back(8'h6F);
        end
        tick();
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k % 4 == 0) cur = exp_q.pop_front();
            exp_seg = (k % 4 == 0) ? 8'h00 : cur;
            checks++;
            if (seg_out !== exp_seg) begin errors++; $display("FAIL coinc_seg k=%0d got %h exp %h", k, seg_out, exp_seg); end
        end
    endtask

    task automatic test_async_reset();
        to_frame_start();
        repeat (3) tick();
        drive_load(16'h5555, 4'b1111, 4'b0000, 1'b0);
        tick();
        load = 1'b0;
        while (cyc % 16 != 9) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dig_sel !== 4'hF) begin errors++; $display("FAIL arst_sel got %b exp 1111", dig_sel); end
        checks++;
        if (seg_out !== 8'h00) begin errors++; $display("FAIL arst_seg got %h exp 00", seg_out); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL arst_fd got %b exp 0", frame_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (8) exp_q.push_back(8'h00);
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k % 4 == 0) cur = exp_q.pop_front();
            exp_seg = (k % 4 == 0) ? 8'h00 : cur;
            exp_sel = 4'hF ^ (4'b0001 << ((k / 4) % 4));
            checks++;
            if (seg_out !== exp_seg) begin errors++; $display("FAIL post_rst_seg k=%0d got %h exp %h", k, seg_out, exp_seg); end
            checks++;
            if (dig_sel !== exp_sel) begin errors++; $display("FAIL post_rst_sel k=%0d got %b exp %b", k, dig_sel, exp_sel); end
        end
    endtask

    initial begin
        test_reset();
        test_load_frame();
        test_lz_hex();
        test_zero_blank();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
